// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and the 16-bit processor it feeds.
package fetch_pkg;

  localparam int DATA_W          = 16;
  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4,
    HALT  = 3'd5
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundles the control, ROM and processor-handshake signals of the fetch unit.
interface instr_fetch_unit_if import fetch_pkg::*; #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = fetch_pkg::DATA_W
);

  logic              Start;
  logic [ADDR_W:0]   ProgLen;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] MemData;
  logic [DATA_W-1:0] DIN;
  logic              Run;
  logic              Done;
  logic              Busy;
  logic              Halted;
  logic              Error;
  logic [ADDR_W:0]   InstrCount;

  modport master (
    input  Start, ProgLen, MemData, Done,
    output ADDR, DIN, Run, Busy, Halted, Error, InstrCount
  );

  modport slave (
    output Start, ProgLen, MemData, Done,
    input  ADDR, DIN, Run, Busy, Halted, Error, InstrCount
  );

endinterface

// File: rtl/instr_fetch_unit_watchdog.sv
// Cycle counter that flags when the processor has taken too long to answer a Run.
module fetch_watchdog import fetch_pkg::*; #(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int              CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // The ISSUE cycle counts as the first elapsed cycle, so expiry lands TIMEOUT cycles after Run.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= CW'(1);
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_enable && (r_count >= LIMIT);

endmodule

// File: rtl/instr_fetch_unit.sv
// Streams a program from a synchronous ROM into the processor, one Run/Done handshake per word.
module instr_fetch_unit import fetch_pkg::*; #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = fetch_pkg::DATA_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input logic Clock,
  input logic Resetn,
  instr_fetch_unit_if.master bus
);

  fetch_state_e      r_state;
  fetch_state_e      w_nextState;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_din;
  logic [ADDR_W:0]   r_instrCount;
  logic [ADDR_W:0]   r_progLen;
  logic              r_error;
  logic [ADDR_W:0]   w_countInc;
  logic              w_wdClear;
  logic              w_wdEnable;
  logic              w_expired;

  assign w_countInc = r_instrCount + 1'b1;

  fetch_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .i_clear   (w_wdClear),
    .i_enable  (w_wdEnable),
    .o_expired (w_expired)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  // Done outranks the watchdog when both land on the same edge.
  always_comb begin
    w_nextState = r_state;
    w_wdClear   = 1'b0;
    w_wdEnable  = 1'b0;
    unique case (r_state)
      IDLE, HALT: begin
        if (bus.Start) w_nextState = (bus.ProgLen == '0) ? HALT : FETCH;
      end
      FETCH: w_nextState = LOAD;
      LOAD:  w_nextState = ISSUE;
      ISSUE: begin
        w_nextState = WAIT;
        w_wdClear   = 1'b1;
      end
      WAIT: begin
        w_wdEnable = 1'b1;
        if (bus.Done)     w_nextState = (w_countInc == r_progLen) ? HALT : FETCH;
        else if (w_expired) w_nextState = HALT;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_pc         <= '0;
      r_din        <= '0;
      r_instrCount <= '0;
      r_progLen    <= '0;
      r_error      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, HALT: begin
          if (bus.Start) begin
            r_pc         <= '0;
            r_instrCount <= '0;
            r_error      <= 1'b0;
            r_progLen    <= bus.ProgLen;
          end
        end
        LOAD: r_din <= bus.MemData;
        WAIT: begin
          if (bus.Done) begin
            r_pc         <= r_pc + 1'b1;
            r_instrCount <= w_countInc;
          end else if (w_expired) begin
            r_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ADDR       = r_pc;
  assign bus.DIN        = r_din;
  assign bus.Run        = (r_state == ISSUE);
  assign bus.Busy       = r_state inside {FETCH, LOAD, ISSUE, WAIT};
  assign bus.Halted     = (r_state == HALT);
  assign bus.Error      = r_error;
  assign bus.InstrCount = r_instrCount;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: ROM and processor models plus a scoreboard of issued words.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int AW  = 8;
  localparam int AW2 = 2;
  localparam int TO  = 16;

  logic Clock  = 1'b0;
  logic Resetn = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;
  int   runCount1 = 0;

  logic [15:0] rom1 [256];
  logic [15:0] rom2 [4];
  logic [15:0] expDin1  [$];
  logic [15:0] expDin2  [$];
  logic [1:0]  expAddr2 [$];
  int          runCycles1 [$];

  always #5 Clock = ~Clock;

  always @(posedge Clock) cycle <= cycle + 1;

  instr_fetch_unit_if #(.ADDR_W(AW),  .DATA_W(DATA_W)) bus1 ();
  instr_fetch_unit_if #(.ADDR_W(AW2), .DATA_W(DATA_W)) bus2 ();

  instr_fetch_unit #(.ADDR_W(AW),  .DATA_W(DATA_W), .TIMEOUT(TO)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus1)
  );

  instr_fetch_unit #(.ADDR_W(AW2), .DATA_W(DATA_W), .TIMEOUT(TO)) dutWrap (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus2)
  );

  // Synchronous ROMs: data appears the cycle after the address is registered.
  always @(posedge Clock) bus1.MemData <= rom1[bus1.ADDR];
  always @(posedge Clock) bus2.MemData <= rom2[bus2.ADDR];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic waitRun(input int which);
    int guard = 0;
    while (((which == 1) ? bus1.Run : bus2.Run) !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    checks++;
    assert (guard < 50) else begin
      errors++;
      $error("FAIL run_timeout dut%0d: observed=no Run expected=Run within 50 cycles", which);
    end
  endtask

  task automatic waitHalt(input int which);
    int guard = 0;
    while (((which == 1) ? bus1.Halted : bus2.Halted) !== 1'b1 && guard < 60) begin
      tick();
      guard++;
    end
  endtask

  task automatic applyStimulus(input int which, input int len);
    if (which == 1) begin
      bus1.ProgLen = 9'(len);
      bus1.Start   = 1'b1;
    end else begin
      bus2.ProgLen = 3'(len);
      bus2.Start   = 1'b1;
    end
    tick();
    bus1.Start = 1'b0;
    bus2.Start = 1'b0;
  endtask

  // Processor model: answers a Run with a one-cycle Done after the given delay.
  task automatic serveDone(input int which, input int delay);
    tick(delay);
    if (which == 1) bus1.Done = 1'b1; else bus2.Done = 1'b1;
    tick();
    if (which == 1) bus1.Done = 1'b0; else bus2.Done = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input int which, input logic halted,
                             input logic busy, input logic err, input int count, input int addr);
    if (which == 1) begin
      check({tag, "_halted"}, 32'(bus1.Halted), 32'(halted));
      check({tag, "_busy"},   32'(bus1.Busy),   32'(busy));
      check({tag, "_error"},  32'(bus1.Error),  32'(err));
      check({tag, "_count"},  32'(bus1.InstrCount), 32'(count));
      check({tag, "_addr"},   32'(bus1.ADDR),   32'(addr));
    end else begin
      check({tag, "_halted"}, 32'(bus2.Halted), 32'(halted));
      check({tag, "_busy"},   32'(bus2.Busy),   32'(busy));
      check({tag, "_error"},  32'(bus2.Error),  32'(err));
      check({tag, "_count"},  32'(bus2.InstrCount), 32'(count));
      check({tag, "_addr"},   32'(bus2.ADDR),   32'(addr));
    end
  endtask

  // Scoreboard monitors: every Run pulse must carry the next expected word.
  initial forever begin
    @(negedge Clock);
    if (Resetn === 1'b1 && bus1.Run === 1'b1) begin
      runCount1++;
      runCycles1.push_back(cycle);
      checks++;
      assert (expDin1.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_run1: observed=Run with DIN=0x%0h expected=no Run", bus1.DIN);
      end
      if (expDin1.size() > 0) check("din1", 32'(bus1.DIN), 32'(expDin1.pop_front()));
    end
  end

  initial forever begin
    @(negedge Clock);
    if (Resetn === 1'b1 && bus2.Run === 1'b1) begin
      checks++;
      assert (expDin2.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_run2: observed=Run with ADDR=%0d expected=no Run", bus2.ADDR);
      end
      if (expDin2.size() > 0) begin
        check("din2",  32'(bus2.DIN),  32'(expDin2.pop_front()));
        check("addr2", 32'(bus2.ADDR), 32'(expAddr2.pop_front()));
      end
    end
  end

  initial begin
    int startCycle;
    int runStart;
    int rc;

    for (int i = 0; i < 256; i++) rom1[i] = 16'(i) ^ 16'h5A00;
    rom1[0] = 16'h1005;
    rom1[1] = 16'h2203;
    rom1[2] = 16'h4400;
    rom2[0] = 16'hA000;
    rom2[1] = 16'hA111;
    rom2[2] = 16'hA222;
    rom2[3] = 16'hA333;
    bus1.Start = 1'b0; bus1.Done = 1'b0; bus1.ProgLen = '0;
    bus2.Start = 1'b0; bus2.Done = 1'b0; bus2.ProgLen = '0;

    // Reset values
    tick(2);
    checkOutput("reset", 1, 1'b0, 1'b0, 1'b0, 0, 0);
    check("reset_run", 32'(bus1.Run), 32'd0);
    check("reset_din", 32'(bus1.DIN), 32'd0);
    Resetn = 1'b1;
    tick(2);

    // Basic three-instruction run
    $display("[TB] basic run");
    expDin1.push_back(16'h1005);
    expDin1.push_back(16'h2203);
    expDin1.push_back(16'h4400);
    runCycles1.delete();
    startCycle = cycle;
    applyStimulus(1, 3);
    for (int i = 0; i < 3; i++) begin
      waitRun(1);
      serveDone(1, 3);
    end
    checkOutput("basic", 1, 1'b1, 1'b0, 1'b0, 3, 3);
    check("basic_latency", 32'(runCycles1[0] - startCycle), 32'd3);
    check("basic_gap01", 32'(runCycles1[1] - runCycles1[0]), 32'd6);
    check("basic_gap12", 32'(runCycles1[2] - runCycles1[1]), 32'd6);
    check("basic_sb_empty", 32'(expDin1.size()), 32'd0);
    tick(3);
    check("basic_hold_din", 32'(bus1.DIN), 32'h4400);
    check("basic_hold_count", 32'(bus1.InstrCount), 32'd3);

    // Zero-length program halts at once
    $display("[TB] zero length");
    rc = runCount1;
    applyStimulus(1, 0);
    checkOutput("zero", 1, 1'b1, 1'b0, 1'b0, 0, 0);
    tick(4);
    check("zero_no_run", 32'(runCount1), 32'(rc));

    // Watchdog: Done never arrives
    $display("[TB] watchdog");
    expDin1.push_back(rom1[0]);
    applyStimulus(1, 2);
    waitRun(1);
    runStart = cycle;
    waitHalt(1);
    check("wd_latency", 32'(cycle - runStart), 32'(TO));
    checkOutput("wd", 1, 1'b1, 1'b0, 1'b1, 0, 0);

    // Spurious Done outside WAIT, Start pulses while busy
    $display("[TB] spurious done");
    expDin1.push_back(rom1[0]);
    expDin1.push_back(rom1[1]);
    expDin1.push_back(rom1[2]);
    applyStimulus(1, 3);
    check("start_clears_error", 32'(bus1.Error), 32'd0);
    bus1.Done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      waitRun(1);
      tick();
      bus1.Done    = 1'b0;
      bus1.Start   = 1'b1;
      bus1.ProgLen = 9'd1;
      tick();
      bus1.Start = 1'b0;
      tick(2);
      check("spur_count_wait", 32'(bus1.InstrCount), 32'(i));
      bus1.Done = 1'b1;
    end
    tick();
    checkOutput("spur", 1, 1'b1, 1'b0, 1'b0, 3, 3);
    tick(3);
    check("spur_halt_ignores_done", 32'(bus1.InstrCount), 32'd3);
    bus1.Done = 1'b0;
    check("spur_sb_empty", 32'(expDin1.size()), 32'd0);

    // PC wrap on the narrow instance
    $display("[TB] wrap");
    for (int i = 0; i < 5; i++) begin
      expDin2.push_back(rom2[i % 4]);
      expAddr2.push_back(2'(i));
    end
    applyStimulus(2, 5);
    for (int i = 0; i < 5; i++) begin
      waitRun(2);
      serveDone(2, 1);
    end
    checkOutput("wrap", 2, 1'b1, 1'b0, 1'b0, 5, 1);
    check("wrap_sb_empty", 32'(expDin2.size()), 32'd0);

    // Reset while waiting on the second instruction
    $display("[TB] reset mid-wait");
    expDin1.push_back(rom1[0]);
    expDin1.push_back(rom1[1]);
    applyStimulus(1, 3);
    waitRun(1);
    serveDone(1, 3);
    waitRun(1);
    tick();
    check("pre_reset_count", 32'(bus1.InstrCount), 32'd1);
    #2;
    Resetn = 1'b0;
    #1;
    check("rst_run", 32'(bus1.Run), 32'd0);
    check("rst_din", 32'(bus1.DIN), 32'd0);
    checkOutput("rst", 1, 1'b0, 1'b0, 1'b0, 0, 0);
    check("rst_wrap_halted", 32'(bus2.Halted), 32'd0);
    tick(2);
    Resetn = 1'b1;
    tick(3);
    checkOutput("post_rst", 1, 1'b0, 1'b0, 1'b0, 0, 0);
    check("rst_sb_empty", 32'(expDin1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed=still running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
